// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for the R10K
// rename stage. Dispatch pops the head tag as T_new; retire pushes the
// ROB's T_free tag back at the tail. A committed copy of the head pointer
// (arch_head) lets a branch_not_taken flush return every speculatively
// allocated tag to the list in a single cycle.
//
// Optional feature: define FREE_LIST_BYPASS_EN to let a tag being retired
// into an empty list be handed to dispatch in the same cycle.
//
// All state updates are written as `<= `SD value`. SD defaults to empty
// and exists only so that an environment can add a delay to every update.

`ifndef SD
`define SD
`endif

module free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dispatch_en,
  input  logic       retire_valid,
  input  logic [6:0] T_free_in,
  input  logic       branch_not_taken,
  output logic [6:0] T_new_out,
  output logic       free_valid,
  output logic [5:0] free_count,
  output logic       free_list_empty
);

  // ---------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------
  // The list only ever holds the physical registers that are not currently
  // mapped to an architectural register.
  localparam int DEPTH   = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int TAG_W   = $clog2(NUM_PHYS_REGS);

  // A T_free value of all ones means the retiring instruction frees no tag.
  localparam logic [6:0]         NO_TAG     = 7'h7F;
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [TAG_W-1:0]   entries [DEPTH];
  logic [PTR_W-1:0]   head;       // speculative pop pointer
  logic [PTR_W-1:0]   arch_head;  // pop pointer as of the last retired instruction
  logic [PTR_W-1:0]   tail;       // push pointer
  logic [COUNT_W-1:0] count;      // tags currently allocatable

  // ---------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------
  logic               flush;
  logic               commit;
  logic               push_req;   // ROB offers a tag this cycle
  logic               push;       // tag is actually written
  logic               pop;        // head tag is actually handed out
  logic               bypass;     // empty list, tag forwarded from T_free_in
  logic               list_empty;
  logic               list_full;

  // Next-state values
  logic [PTR_W-1:0]   head_next;
  logic [PTR_W-1:0]   arch_head_next;
  logic [PTR_W-1:0]   tail_next;
  logic [COUNT_W-1:0] count_next;
  logic [PTR_W-1:0]   flush_span;

  assign flush      = branch_not_taken;
  assign commit     = retire_valid;
  assign push_req   = retire_valid && (T_free_in != NO_TAG);
  assign list_empty = (count == '0);
  assign list_full  = (count == FULL_COUNT);

  // Decide whether the empty-list bypass is active this cycle.
`ifdef FREE_LIST_BYPASS_EN
  // A flush rewinds head anyway, so forwarding a tag then would hand out a
  // tag that the flush immediately reclaims; bypass is held off.
  assign bypass = list_empty && push_req && !flush;
`else
  assign bypass = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs: zero-latency read of the head entry
  // ---------------------------------------------------------------------
  // Drive the allocation port from the head entry or, when forwarding, from
  // the incoming retire tag.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch so
    // that no path can leave it unassigned and infer a latch.
    free_valid = 1'b0;
    T_new_out  = NO_TAG;
    if (!list_empty) begin
      free_valid = 1'b1;
      T_new_out  = {1'b0, entries[head]};
    end else if (bypass) begin
      free_valid = 1'b1;
      T_new_out  = {1'b0, T_free_in[TAG_W-1:0]};
    end
  end

  assign free_count      = count;
  assign free_list_empty = list_empty;

  // ---------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------
  // Resolve which pop and push actually take effect this cycle.
  always_comb begin
    // Dispatch must stall on free_valid; a request without it is a no-op,
    // and a flush discards any pop made in the same cycle.
    pop  = dispatch_en && free_valid && !flush;
    // Pushing into a full list without a matching pop cannot happen in a
    // consistent machine; if it does, the tag is dropped rather than
    // overwriting a live entry.
    push = push_req && !(list_full && !pop);
  end

  // ---------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------
  // Advance the pointers and count; a flush rewinds head to the post-commit
  // arch_head and recomputes the count from the rewound span.
  always_comb begin
    arch_head_next = arch_head + PTR_W'(commit);
    tail_next      = tail + PTR_W'(push);
    flush_span     = tail_next - arch_head_next;

    head_next  = head;
    count_next = count;

    if (flush) begin
      head_next = arch_head_next;
      // Every tag between arch_head and tail is free again. An equal pair
      // of pointers means the ring is completely full, never empty, since
      // no speculative allocation survives the flush.
      if (flush_span == '0) begin
        count_next = FULL_COUNT;
      end else begin
        count_next = {1'b0, flush_span};
      end
    end else begin
      if (pop) begin
        head_next = head + 1'b1;
      end
      // A bypassed pop and its push cancel, leaving the count at zero.
      unique case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Load the initial tag set on reset, otherwise apply this cycle's events.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the entry array is reset on purpose: at power-up the list
      // must already hold tags NUM_ARCH_REGS..NUM_PHYS_REGS-1, so it is
      // built from flops rather than an unresettable RAM.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i[PTR_W-1:0]] <= `SD TAG_W'(NUM_ARCH_REGS + i);
      end
      head      <= `SD '0;
      arch_head <= `SD '0;
      tail      <= `SD '0;
      count     <= `SD FULL_COUNT;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values computed above.
      if (push) begin
        // In a bypass the entry is still written; head simply moves past it.
        entries[tail] <= `SD T_free_in[TAG_W-1:0];
      end
      head      <= `SD head_next;
      arch_head <= `SD arch_head_next;
      tail      <= `SD tail_next;
      count     <= `SD count_next;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: self-checking bench for free_list. A behavioural model
// keeps the allocatable tags and the in-flight (allocated, not yet retired)
// tags as two queues. Each cycle the model's expected outputs are pushed to
// a scoreboard queue when stimulus is driven and popped and compared once
// the DUT outputs have settled, half a clock away from the active edge.

module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic       dispatch_en;
  logic       retire_valid;
  logic [6:0] T_free_in;
  logic       branch_not_taken;
  logic [6:0] T_new_out;
  logic       free_valid;
  logic [5:0] free_count;
  logic       free_list_empty;

  free_list dut (
    .clock           (clock),
    .reset           (reset),
    .dispatch_en     (dispatch_en),
    .retire_valid    (retire_valid),
    .T_free_in       (T_free_in),
    .branch_not_taken(branch_not_taken),
    .T_new_out       (T_new_out),
    .free_valid      (free_valid),
    .free_count      (free_count),
    .free_list_empty (free_list_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] tag;
    logic       valid;
    logic [5:0] count;
    logic       empty;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] free_q[$];
  logic [5:0] inflight_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    inflight_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
  endtask

  // Pop the oldest expectation and compare it with the settled outputs.
  task automatic compare_outputs(input string phase);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({phase, " scoreboard_underflow"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({phase, " T_new_out"},       32'(T_new_out),       32'(e.tag));
    check({phase, " free_valid"},      32'(free_valid),      32'(e.valid));
    check({phase, " free_count"},      32'(free_count),      32'(e.count));
    check({phase, " free_list_empty"}, 32'(free_list_empty), 32'(e.empty));
  endtask

  // Drive one cycle of stimulus, predict and check outputs, then advance
  // the model past the coming clock edge.
  task automatic cycle(input string phase, input logic rst, input logic disp,
                       input logic ret, input logic [6:0] tfree,
                       input logic flush);
    exp_t e;
    logic push_req;
    logic bypass;
    logic pop_ok;
    logic push;
    @(negedge clock);
    reset            = rst;
    dispatch_en      = disp;
    retire_valid     = ret;
    T_free_in        = tfree;
    branch_not_taken = flush;
    #1;
    push_req = ret && (tfree != 7'h7F);
    bypass   = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    bypass = (free_q.size() == 0) && push_req && !flush;
`endif
    e.count = 6'(free_q.size());
    e.empty = (free_q.size() == 0);
    e.valid = !e.empty || bypass;
    if (!e.empty)    e.tag = {1'b0, free_q[0]};
    else if (bypass) e.tag = {1'b0, tfree[5:0]};
    else             e.tag = 7'h7F;
    exp_q.push_back(e);
    compare_outputs(phase);

    if (rst) begin
      model_reset();
    end else begin
      pop_ok = disp && e.valid && !flush;
      push   = push_req && !((free_q.size() == 32) && !pop_ok);
      // The retiring instruction is always the oldest allocation.
      if (ret && inflight_q.size() > 0) void'(inflight_q.pop_front());
      if (pop_ok && e.empty) begin
        // Forwarded tag goes straight to the new instruction.
        inflight_q.push_back(tfree[5:0]);
      end else begin
        if (pop_ok) inflight_q.push_back(free_q.pop_front());
        if (push)   free_q.push_back(tfree[5:0]);
      end
      if (flush) begin
        free_q = {inflight_q, free_q};
        inflight_q.delete();
      end
    end
  endtask

  task automatic idle(input string phase);
    cycle(phase, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b0);
  endtask

  task automatic do_reset();
    cycle("reset", 1'b1, 1'b0, 1'b0, 7'h7F, 1'b0);
    cycle("reset", 1'b1, 1'b0, 1'b0, 7'h7F, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    dispatch_en      = 1'b0;
    retire_valid     = 1'b0;
    T_free_in        = 7'h7F;
    branch_not_taken = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    do_reset();

    // Reset state, then drain all 32 tags in order.
    idle("after_reset");
    for (int i = 0; i < 32; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    idle("drained");
    cycle("drained_pop", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);

    // Retire into an empty list, then pop it back out.
    cycle("retire_empty", 1'b0, 1'b0, 1'b1, 7'h45, 1'b0);
    idle("one_free");
    cycle("pop_single", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    // Retire and dispatch together at empty: forwarded only with bypass.
    cycle("retire_pop_empty", 1'b0, 1'b1, 1'b1, 7'h45, 1'b0);
    idle("after_retire_pop");

    // Pop 5, retire 2, flush: tags 34.. come back, 3 and 4 at the end.
    do_reset();
    for (int i = 0; i < 5; i++) cycle("spec_pop", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    cycle("retire_3", 1'b0, 1'b0, 1'b1, 7'h03, 1'b0);
    cycle("retire_4", 1'b0, 1'b0, 1'b1, 7'h04, 1'b0);
    cycle("flush", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b1);
    idle("after_flush");
    for (int i = 0; i < 32; i++) cycle("post_flush_pop", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    idle("post_flush_empty");

    // Retire without a tag: commit only; visible through a later flush.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("pop3", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    cycle("retire_no_tag", 1'b0, 1'b0, 1'b1, 7'h7F, 1'b0);
    idle("after_no_tag");
    cycle("flush_no_tag", 1'b0, 1'b0, 1'b0, 7'h7F, 1'b1);
    idle("after_flush_no_tag");

    // Push into a full list with no pop: dropped.
    do_reset();
    cycle("push_full", 1'b0, 1'b0, 1'b1, 7'h11, 1'b0);
    idle("after_push_full");

    // Wrap-around: 40 paired pop/push cycles, pointers pass 31 -> 0.
    do_reset();
    cycle("wrap_first_pop", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);
    for (int i = 0; i < 40; i++)
      cycle("wrap", 1'b0, 1'b1, 1'b1, 7'((i * 5 + 1) % 64), 1'b0);
    idle("after_wrap");
    cycle("wrap_flush", 1'b0, 1'b0, 1'b1, 7'h2A, 1'b1);
    idle("after_wrap_flush");
    for (int i = 0; i < 6; i++) cycle("wrap_tail_pop", 1'b0, 1'b1, 1'b0, 7'h7F, 1'b0);

    // Reset beats flush, push and pop in the same cycle.
    cycle("reset_all", 1'b1, 1'b1, 1'b1, 7'h05, 1'b1);
    idle("after_reset_all");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
